// File: rtl/rom_loader.sv
// ROM backdoor loader: halts the system and streams bytes into ROM over single wishbone writes.
// Optional build macro ROM_LOADER_CHECKSUM_EN enables the running 8-bit checksum of acked bytes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; outputs quiet, checksum/error held
// HALT_WAIT | halt asserted, letting CPU/ROMs settle for HALT_DELAY cycles
// FETCH     | byte_ready high, waiting for a stream byte
// WRITE     | wishbone write in flight, waiting for ack or timeout
// DONE      | one-cycle done pulse, halt released
module rom_loader #(
  parameter int HALT_DELAY = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] start_addr,
  input  logic [11:0] length,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        halt,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  checksum,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] rem_q, rem_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  timer_q, timer_d;
  logic        err_q, err_d;
  logic        abort_pend_q, abort_pend_d;
  logic        start_acc;
  logic        commit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= 12'h000;
      rem_q        <= 12'h000;
      data_q       <= 8'h00;
      timer_q      <= 8'h00;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // One down-counter serves as the halt settle timer and the write ack timeout.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    data_d       = data_q;
    timer_d      = timer_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    start_acc    = 1'b0;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          start_acc    = 1'b1;
          addr_d       = start_addr;
          rem_d        = length;
          err_d        = 1'b0;
          abort_pend_d = 1'b0;
          timer_d      = 8'(HALT_DELAY - 1);
          state_d      = (length == 12'h000) ? S_DONE : S_HALT_WAIT;
        end
      end

      S_HALT_WAIT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (timer_q == 8'h00) begin
          state_d = S_FETCH;
        end else begin
          timer_d = timer_q - 8'h01;
        end
      end

      S_FETCH: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (byte_valid) begin
          data_d       = byte_data;
          timer_d      = 8'(TIMEOUT - 1);
          abort_pend_d = 1'b0;
          state_d      = S_WRITE;
        end
      end

      S_WRITE: begin
        if (wb_ack_i) begin
          commit = 1'b1;
          addr_d = addr_q + 12'h001;
          rem_d  = rem_q - 12'h001;
          if (abort || abort_pend_q) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (rem_q == 12'h001) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else if (timer_q == 8'h00) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 8'h01;
          // An abort during a write is remembered and honoured once the write completes.
          if (abort) abort_pend_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) csum_d = 8'h00;
    else if (commit) csum_d = csum_q + data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) csum_q <= 8'h00;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign busy        = (state_q == S_HALT_WAIT) || (state_q == S_FETCH) || (state_q == S_WRITE);
  assign halt        = busy;
  assign byte_ready  = (state_q == S_FETCH);
  assign done        = (state_q == S_DONE);
  assign error       = err_q;
  assign wb_cyc_o    = (state_q == S_WRITE);
  assign wb_strobe_o = wb_cyc_o;
  assign wb_we_o     = wb_cyc_o;
  assign wb_addr_o   = {18'b0, addr_q, 2'b00};
  assign wb_data_o   = {24'b0, data_q};

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: table-driven nominal session plus corner sequences.
module tb_rom_loader;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort, byte_valid, wb_ack_i;
  logic [11:0] start_addr, length;
  logic [7:0]  byte_data;
  logic        byte_ready, halt, busy, done, error;
  logic [7:0]  checksum;
  logic        wb_cyc_o, wb_strobe_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_data_o;

  int n_chk  = 0;
  int n_fail = 0;

  rom_loader #(.HALT_DELAY(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .start_addr(start_addr), .length(length), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .halt(halt), .busy(busy),
    .done(done), .error(error), .checksum(checksum), .wb_cyc_o(wb_cyc_o),
    .wb_strobe_o(wb_strobe_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st, ab, v, ack;
    logic [11:0] sa, len;
    logic [7:0]  d;
    logic        e_halt, e_busy, e_done, e_rdy, e_cyc, e_err;
    logic [31:0] e_addr;
    logic [7:0]  e_data, e_cs;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic st, logic [11:0] sa, logic [11:0] len, logic v,
                              logic [7:0] d, logic ack, logic e_halt, logic e_busy,
                              logic e_done, logic e_rdy, logic e_cyc, logic e_err,
                              logic [31:0] e_addr, logic [7:0] e_data, logic [7:0] e_cs);
    vec_t r;
    r.st = st; r.ab = 1'b0; r.sa = sa; r.len = len; r.v = v; r.d = d; r.ack = ack;
    r.e_halt = e_halt; r.e_busy = e_busy; r.e_done = e_done; r.e_rdy = e_rdy;
    r.e_cyc = e_cyc; r.e_err = e_err; r.e_addr = e_addr; r.e_data = e_data; r.e_cs = e_cs;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; byte_valid = 0; wb_ack_i = 0; byte_data = 8'h00;
    start_addr = 12'h000; length = 12'h000;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!byte_ready && k < 20) begin
      step();
      k++;
    end
    chk(nm, {31'b0, byte_ready}, 32'd1);
  endtask

  function automatic logic [7:0] cs_exp(input logic [7:0] v);
    return CS_EN ? v : 8'h00;
  endfunction

  initial begin
    // start_addr 0x0FE, 3 bytes, ack latency 1; a stray ack in HALT_WAIT and a start in WRITE are ignored
    tbl[0]  = mk(1, 12'h0FE, 12'd3, 0, 8'h00, 0, 1,1,0,0,0,0, 32'h3F8, 8'h00, 8'h00);
    tbl[1]  = mk(0, 12'h000, 12'd0, 0, 8'h00, 1, 1,1,0,0,0,0, 32'h3F8, 8'h00, 8'h00);
    tbl[2]  = mk(0, 12'h000, 12'd0, 0, 8'h00, 0, 1,1,0,1,0,0, 32'h3F8, 8'h00, 8'h00);
    tbl[3]  = mk(0, 12'h000, 12'd0, 1, 8'h11, 0, 1,1,0,0,1,0, 32'h3F8, 8'h11, 8'h00);
    tbl[4]  = mk(1, 12'h555, 12'd7, 0, 8'h00, 0, 1,1,0,0,1,0, 32'h3F8, 8'h11, 8'h00);
    tbl[5]  = mk(0, 12'h000, 12'd0, 0, 8'h00, 1, 1,1,0,1,0,0, 32'h3FC, 8'h11, 8'h11);
    tbl[6]  = mk(0, 12'h000, 12'd0, 1, 8'h22, 0, 1,1,0,0,1,0, 32'h3FC, 8'h22, 8'h11);
    tbl[7]  = mk(0, 12'h000, 12'd0, 0, 8'h00, 0, 1,1,0,0,1,0, 32'h3FC, 8'h22, 8'h11);
    tbl[8]  = mk(0, 12'h000, 12'd0, 0, 8'h00, 1, 1,1,0,1,0,0, 32'h400, 8'h22, 8'h33);
    tbl[9]  = mk(0, 12'h000, 12'd0, 1, 8'h33, 0, 1,1,0,0,1,0, 32'h400, 8'h33, 8'h33);
    tbl[10] = mk(0, 12'h000, 12'd0, 0, 8'h00, 0, 1,1,0,0,1,0, 32'h400, 8'h33, 8'h33);
    tbl[11] = mk(0, 12'h000, 12'd0, 0, 8'h00, 1, 0,0,1,0,0,0, 32'h404, 8'h33, 8'h66);
    tbl[12] = mk(0, 12'h000, 12'd0, 0, 8'h00, 0, 0,0,0,0,0,0, 32'h404, 8'h33, 8'h66);

    idle_inputs();
    reset_n = 0;
    repeat (2) @(negedge clock);
    chk("rst_halt", {31'b0, halt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_outs", {25'b0, done, error, byte_ready, wb_cyc_o, wb_strobe_o, wb_we_o, 1'b0}, 0);
    chk("rst_addr", wb_addr_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_cs", {24'b0, checksum}, 0);
    reset_n = 1;
    step();

    // nominal session from the table; done lands 12 cycles after the start edge's cycle
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; start_addr = tbl[i].sa; length = tbl[i].len;
      byte_valid = tbl[i].v; byte_data = tbl[i].d; wb_ack_i = tbl[i].ack;
      step();
      chk($sformatf("v%0d_halt", i), {31'b0, halt}, {31'b0, tbl[i].e_halt});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, tbl[i].e_done});
      chk($sformatf("v%0d_rdy", i), {31'b0, byte_ready}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("v%0d_wb", i), {29'b0, wb_cyc_o, wb_strobe_o, wb_we_o},
          {29'b0, {3{tbl[i].e_cyc}}});
      chk($sformatf("v%0d_err", i), {31'b0, error}, {31'b0, tbl[i].e_err});
      chk($sformatf("v%0d_addr", i), wb_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_data", i), wb_data_o, {24'b0, tbl[i].e_data});
      chk($sformatf("v%0d_cs", i), {24'b0, checksum}, {24'b0, cs_exp(tbl[i].e_cs)});
    end
    idle_inputs();

    // address wrap 0xFFF -> 0x000 with halt held throughout
    begin
      logic [31:0] addrs[$];
      int hb, w, got_done;
      hb = 1; w = 0; got_done = 0;
      start = 1; start_addr = 12'hFFF; length = 12'd2;
      step();
      idle_inputs();
      byte_valid = 1; byte_data = 8'h5A;
      for (int i = 0; i < 30; i++) begin
        if (done) begin
          got_done = 1;
          break;
        end
        if (!halt) hb = 0;
        wb_ack_i = 0;
        if (wb_cyc_o) begin
          if (w == 0) begin
            w = 1;
            addrs.push_back(wb_addr_o);
          end else begin
            wb_ack_i = 1;
            w = 0;
          end
        end
        step();
      end
      idle_inputs();
      chk("wrap_done", got_done, 1);
      chk("wrap_halt", hb, 1);
      chk("wrap_nwr", addrs.size(), 2);
      if (addrs.size() == 2) begin
        chk("wrap_a0", addrs[0], 32'h3FFC);
        chk("wrap_a1", addrs[1], 32'h0);
      end
    end
    step();

    // empty session
    start = 1; start_addr = 12'h123; length = 12'd0;
    step();
    idle_inputs();
    chk("len0_done", {31'b0, done}, 1);
    chk("len0_halt", {31'b0, halt}, 0);
    chk("len0_cyc", {31'b0, wb_cyc_o}, 0);
    step();
    chk("len0_idle", {30'b0, done, halt}, 0);

    // write timeout: cyc high exactly 16 cycles
    begin
      int cnt;
      start = 1; start_addr = 12'h200; length = 12'd1;
      step();
      idle_inputs();
      wait_ready("tmo_ready");
      byte_valid = 1; byte_data = 8'h77;
      step();
      byte_valid = 0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (done) break;
        if (wb_cyc_o) cnt++;
        step();
      end
      chk("tmo_cycles", cnt, 16);
      chk("tmo_done", {31'b0, done}, 1);
      chk("tmo_err", {31'b0, error}, 1);
      chk("tmo_halt", {31'b0, halt}, 0);
      chk("tmo_cs", {24'b0, checksum}, 0);
    end
    step();

    // abort during HALT_WAIT
    start = 1; start_addr = 12'h300; length = 12'd5;
    step();
    idle_inputs();
    chk("abh_err_clr", {31'b0, error}, 0);
    abort = 1;
    step();
    abort = 0;
    chk("abh_done", {31'b0, done}, 1);
    chk("abh_err", {31'b0, error}, 1);
    step();

    // abort together with the ack of byte 1 of 4
    begin
      int rdy_seen;
      start = 1; start_addr = 12'h010; length = 12'd4;
      step();
      idle_inputs();
      chk("aba_err_clr", {31'b0, error}, 0);
      wait_ready("aba_ready");
      byte_valid = 1; byte_data = 8'hA5;
      step();
      byte_valid = 0;
      chk("aba_cyc", {31'b0, wb_cyc_o}, 1);
      step();
      wb_ack_i = 1; abort = 1;
      step();
      idle_inputs();
      byte_valid = 1;
      chk("aba_done", {31'b0, done}, 1);
      chk("aba_err", {31'b0, error}, 1);
      chk("aba_addr", wb_addr_o, 32'h44);
      chk("aba_cs", {24'b0, checksum}, {24'b0, cs_exp(8'hA5)});
      rdy_seen = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (byte_ready) rdy_seen = 1;
      end
      byte_valid = 0;
      chk("aba_no_rdy", rdy_seen, 0);
      start = 1; length = 12'd0;
      step();
      idle_inputs();
      chk("aba_restart_err", {31'b0, error}, 0);
      chk("aba_restart_cs", {24'b0, checksum}, 0);
      step();
    end

    // asynchronous reset in the middle of a write
    start = 1; start_addr = 12'h080; length = 12'd2;
    step();
    idle_inputs();
    wait_ready("rstw_ready");
    byte_valid = 1; byte_data = 8'h3C;
    step();
    byte_valid = 0;
    chk("rstw_cyc_pre", {31'b0, wb_cyc_o}, 1);
    #2 reset_n = 0;
    #1;
    chk("rstw_cyc", {31'b0, wb_cyc_o}, 0);
    chk("rstw_halt", {31'b0, halt}, 0);
    chk("rstw_busy", {31'b0, busy}, 0);
    @(negedge clock);
    reset_n = 1;
    step();
    chk("rstw_idle", {28'b0, busy, done, byte_ready, wb_cyc_o}, 0);
    chk("rstw_addr", wb_addr_o, 0);
    step();
    chk("rstw_idle2", {30'b0, busy, halt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Sequencer that owns the ROM wishbone write backdoor and programs ROM contents from a byte stream while the system is halted. On `start` it asserts `halt` to freeze the CPU and every ROM chip. It then writes `length` bytes from a valid/ready stream to consecutive 12-bit ROM addresses (chip ID in bits [11:8]) as single wishbone write cycles, and releases `halt` when finished. It sits between the host-side loader (SPI/UART bridge) and the shared wishbone bus feeding all ROM chips.

## Interface
- `HALT_DELAY`, 2, cycles `halt` is held before the first byte is requested (1..15)
- `TIMEOUT`, 16, max cycles spent in a write waiting for `wb_ack_i` before aborting (1..255)
- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin load session; sampled only in IDLE
- `abort`  in  1  end session at next safe point
- `start_addr`  in  12  first ROM address {chip_id[3:0], byte[7:0]}, captured on accepted `start`
- `length`  in  12  byte count, captured on accepted `start`; 0 = empty session
- `byte_valid`  in  1  stream data valid
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  loader accepts byte this cycle
- `halt`  out  1  freeze to CPU and ROMs
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse at session end
- `error`  out  1  sticky; set on timeout or abort, cleared on next accepted `start`
- `checksum`  out  8  running byte sum (see Configuration)
- `wb_cyc_o`, `wb_strobe_o`, `wb_we_o`  out  1 each  wishbone master controls; all three move together
- `wb_addr_o`  out  32  {18'b0, addr[11:0], 2'b00}
- `wb_data_o`  out  32  {24'b0, byte}
- `wb_ack_i`  in  1  write acknowledge

## Operation
- States: IDLE, HALT_WAIT, FETCH, WRITE, DONE.
- IDLE: `start`=1 and `abort`=0 captures `start_addr`/`length` and clears `error`, `checksum`.
  - `length`≠0 → HALT_WAIT.
  - `length`=0 → DONE; `halt` is never asserted.
  - `start` in any other state is ignored.
  - `abort` alone in IDLE has no effect.
- HALT_WAIT: `halt`=1; counts HALT_DELAY cycles, then → FETCH. `abort` → DONE with `error`=1.
- FETCH: `byte_ready`=1. A byte is accepted on an edge with `byte_valid`&&`byte_ready`; it is registered onto `wb_data_o` and the state goes → WRITE. `abort` (with or without a valid byte) → DONE, `error`=1, byte not consumed.
- WRITE: `wb_cyc_o`=`wb_strobe_o`=`wb_we_o`=1, address and data stable. Edge with `wb_ack_i`=1:
  - address increments modulo 4096 (0xFFF wraps to 0x000);
  - remaining count decrements and checksum accumulates;
  - → DONE if remaining reaches 0 or `abort` is high, else → FETCH.
  - `abort` never truncates an in-flight write.
- WRITE timeout: TIMEOUT cycles without ack → `error`=1, → DONE; the byte is not counted.
- DONE: single cycle. `halt`=0, `busy`=0, `done`=1, wishbone controls low; → IDLE.
- `busy`=1 in HALT_WAIT, FETCH and WRITE. `halt`=1 in HALT_WAIT, FETCH and WRITE.

## Timing
- Reset (async assert on `reset_n` low; `reset_n` is synchronised for deassertion elsewhere): state IDLE. All outputs 0: `halt`, `busy`, `done`, `error`, `byte_ready`, `checksum`, wb controls, `wb_addr_o`, `wb_data_o`. A reset mid-write drops `wb_cyc_o` immediately and releases `halt`.
- All outputs are registered or decoded from the state register only; none depends combinationally on an input.
- Start at edge T: `halt`/`busy` high from T+1; FETCH entered at T+1+HALT_DELAY.
- Per byte with ROM ack latency 1: FETCH 1 cycle (stream always valid) + WRITE 2 cycles = 3 cycles/byte.
- The wishbone controls drop the cycle after the ack edge. The ROM's own `!wb_ack_o` guard prevents a double write during the overlap cycle.
- A session of N bytes with always-valid stream and ack latency 1: `done` pulses at T+1+HALT_DELAY+3N.
- `wb_ack_i` outside WRITE is ignored.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined: `checksum` = 8-bit wrap-around sum of all acked bytes in the current session. It is held after DONE until the next accepted `start`.
- Not defined: `checksum` tied to 0 and no accumulator is synthesised.

## Test plan
- Reset during WRITE (`reset_n` low mid-transaction) → `wb_cyc_o`, `halt`, `busy` go 0 without waiting for a clock edge; after release, state is IDLE.
- `start_addr`=0x0FE, `length`=3, bytes 0x11,0x22,0x33, ack latency 1 → writes at `wb_addr_o` 0x3F8, 0x3FC, 0x400 (address 0x100, chip 1). `done` pulses at T+12 with HALT_DELAY=2; `checksum`=0x66 (with EN); `error`=0.
- `start_addr`=0xFFF, `length`=2 → second write at `wb_addr_o`=0x0 (wrap); `halt` high for the whole session.
- `length`=0 → `done` pulse at T+1, `halt` never high, no wishbone cycle.
- `wb_ack_i` held 0 with TIMEOUT=16 → `wb_cyc_o` high exactly 16 cycles, then `error`=1, `done` pulse, `halt`=0.
- `abort` asserted in the same cycle the ack arrives on byte 1 of 4 → byte 1 committed, `done` next cycle, `error`=1, `byte_ready` never reasserts. A subsequent `start` clears `error`.
